// File: rtl/lvds_rx_align_ctrl_pkg.sv
// Shared definitions for the LVDS receive word-alignment controller.
// This package holds the FSM state type, the default training word,
// the counter widths and a small clog2 helper used for port sizing.
package lvds_rx_align_ctrl_pkg;

  // Alignment FSM states. The 3-bit encoding is fixed here so that every
  // user of the package sees the same values.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_LOCKED = 3'd5
  } align_state_e;

  // Training word the lane hunts for when no override is given.
  localparam logic [7:0] DEFAULT_TRAIN = 8'h35;

  // Match and loss thresholds go up to 255, so 8 bits is enough.
  localparam int CNT_W = 8;

  // The settle count goes up to 15, so 4 bits is enough.
  localparam int WAIT_W = 4;

  // Ceiling log2 with a floor of one bit, so that a port width is never zero.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/lvds_rx_align_ctrl_sat_cnt.sv
// Saturating up-counter used for the match, loss and settle counts.
// When clr is high the count restarts. If inc is also high, the count
// restarts at one, so "first hit" can be loaded in a single cycle.
// at_max is high while the count sits at MAX.
module lvds_rx_align_ctrl_sat_cnt #(
  parameter int CW  = 8,
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // Next count: restart on clear, otherwise step up and stop at MAX.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = (inc && (MAX_V != '0)) ? CW'(1) : '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register, cleared by the lane reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// Word-alignment controller for one LVDS receive lane.
// The block hunts for the training word and pulses bitslip to the gearbox
// until the framing matches. It declares lock after enough consecutive
// matches, then forwards payload words until a run of code errors drops
// the lock again.
module lvds_rx_align_ctrl
  import lvds_rx_align_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TRAIN     = WIDTH'(DEFAULT_TRAIN),
  parameter int               LOCK_CNT  = 16,
  parameter int               LOSS_CNT  = 4,
  parameter int               SLIP_WAIT = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [WIDTH-1:0]               din,
  input  logic                           din_valid,
  input  logic                           din_err,
  output logic                           bitslip,
  output logic                           locked,
  output logic                           align_err,
  output logic [clog2_min1(WIDTH)-1:0]   slip_cnt,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_valid
);

  localparam int                SLIP_W    = clog2_min1(WIDTH);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(WIDTH - 1);

  align_state_e      state_d, state_q;
  logic              bitslip_d, bitslip_q;
  logic              locked_d, locked_q;
  logic              align_err_d, align_err_q;
  logic [SLIP_W-1:0] slip_cnt_d, slip_cnt_q;
  logic [WIDTH-1:0]  dout_d, dout_q;
  logic              dout_valid_d, dout_valid_q;

  logic train_hit;
  logic match_clr, match_inc, match_done;
  logic loss_clr, loss_inc, loss_done;
  logic wait_clr, wait_inc, wait_done;

  assign train_hit = (din == TRAIN);

  // Match count. A hit in HUNT loads one, and each further hit in VERIFY
  // adds one. The count restarts everywhere else, and on a miss in VERIFY.
  assign match_clr = !en || (state_q != ST_VERIFY) || (din_valid && !train_hit);
  assign match_inc = en && din_valid && train_hit &&
                     ((state_q == ST_HUNT) || (state_q == ST_VERIFY));

  // Loss count. It tracks consecutive valid errored words while locked,
  // and a clean valid word restarts it.
  assign loss_clr = !en || (state_q != ST_LOCKED) || (din_valid && !din_err);
  assign loss_inc = en && (state_q == ST_LOCKED) && din_valid && din_err;

  // Settle count. It counts the valid words discarded after a bitslip.
  assign wait_clr = !en || (state_q != ST_WAIT);
  assign wait_inc = en && (state_q == ST_WAIT) && din_valid;

  // The at_max flags fire one word early, so the word that reaches the
  // threshold moves the FSM on the same edge.
  lvds_rx_align_ctrl_sat_cnt #(.CW(CNT_W), .MAX(LOCK_CNT - 1)) u_match_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (match_clr),
    .inc    (match_inc),
    .at_max (match_done)
  );

  lvds_rx_align_ctrl_sat_cnt #(.CW(CNT_W), .MAX(LOSS_CNT - 1)) u_loss_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (loss_clr),
    .inc    (loss_inc),
    .at_max (loss_done)
  );

  lvds_rx_align_ctrl_sat_cnt #(.CW(WAIT_W), .MAX(SLIP_WAIT - 1)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .at_max (wait_done)
  );

  // Next state and next register values. Every output is derived from the
  // state being entered, so bitslip and locked line up with that state.
  always_comb begin
    state_d      = state_q;
    bitslip_d    = 1'b0;
    locked_d     = 1'b0;
    align_err_d  = align_err_q;
    slip_cnt_d   = slip_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (!en) begin
      state_d     = ST_IDLE;
      align_err_d = 1'b0;
      slip_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (din_valid) begin
            state_d = train_hit ? ST_VERIFY : ST_SLIP;
          end
        end
        ST_SLIP: state_d = ST_WAIT;
        ST_WAIT: begin
          if (din_valid && wait_done) begin
            state_d = ST_HUNT;
          end
        end
        ST_VERIFY: begin
          if (din_valid) begin
            if (!train_hit) begin
              state_d = ST_SLIP;
            end else if (match_done) begin
              state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (din_valid && din_err && loss_done) begin
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // SLIP always lasts one cycle, so entering it gives a one-cycle pulse.
      // All phases have been tried once the slip count wraps.
      if (state_d == ST_SLIP) begin
        bitslip_d = 1'b1;
        if (slip_cnt_q == SLIP_LAST) begin
          slip_cnt_d  = '0;
          align_err_d = 1'b1;
        end else begin
          slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        end
      end

      // Payload is forwarded only while the lane stays locked. The word that
      // completes the lock is therefore dropped, and so is the word that
      // loses it.
      if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
        dout_d       = din;
        dout_valid_d = din_valid;
      end

      locked_d = (state_d == ST_LOCKED);
    end
  end

  // FSM state and all registered outputs, cleared by the lane reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
      slip_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      align_err_q  <= align_err_d;
      slip_cnt_q   <= slip_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;
  assign slip_cnt   = slip_cnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Self-checking bench for lvds_rx_align_ctrl.
// A lane-level reference model runs beside the DUT. On top of that there is
// a table of constant vectors, a few directed corner sequences and a
// randomized run. A simple gearbox model rotates the training word and
// reacts to bitslip.
module tb_lvds_rx_align_ctrl;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] TRAIN     = 8'h35;
  localparam int         LOCK_CNT  = 16;
  localparam int         LOSS_CNT  = 4;
  localparam int         SLIP_WAIT = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       en        = 1'b0;
  logic [7:0] din       = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_err   = 1'b0;
  logic       bitslip;
  logic       locked;
  logic       align_err;
  logic [2:0] slip_cnt;
  logic [7:0] dout;
  logic       dout_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: the lane mode as a name plus plain integer counts.
  string      m_mode;
  int         m_match, m_loss, m_wait, m_slips;
  logic       e_bitslip, e_locked, e_aerr, e_dvalid;
  logic [7:0] e_dout;

  int         gb_mis = 0;
  logic       prev_bitslip = 1'b0;
  int         n_slips, last_slip, nvalid, lock_cycles;
  logic       v_bit, e_bit, r_err;
  logic [7:0] d_byte;

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       valid;
    logic       err;
    int         reps;
    logic       e_locked;
    logic       e_bitslip;
    logic [2:0] e_slip;
    logic       e_aerr;
    logic       e_dvalid;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[13];

  lvds_rx_align_ctrl #(
    .WIDTH(WIDTH), .TRAIN(TRAIN), .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_err(din_err), .bitslip(bitslip), .locked(locked), .align_err(align_err),
    .slip_cnt(slip_cnt), .dout(dout), .dout_valid(dout_valid)
  );

  // Word clock.
  always #5 clk = ~clk;

  // Safety net so that a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int m);
    return (w << m) | (w >> (8 - m));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_mode    = "idle";
    m_match   = 0;
    m_loss    = 0;
    m_wait    = 0;
    m_slips   = 0;
    e_bitslip = 1'b0;
    e_locked  = 1'b0;
    e_aerr    = 1'b0;
    e_dvalid  = 1'b0;
    e_dout    = 8'h00;
  endtask

  // One word time of the lane behaviour, computed from the inputs seen at the edge.
  task automatic model_step(input logic en_i, input logic [7:0] din_i, input logic v_i, input logic err_i);
    string prev;
    bit    hit;
    prev = m_mode;
    hit  = (din_i == TRAIN);
    if (!en_i) begin
      m_mode  = "idle";
      m_slips = 0;
      e_aerr  = 1'b0;
    end else if (prev == "idle") begin
      m_mode = "hunt";
    end else if (prev == "hunt") begin
      if (v_i) begin
        if (hit) begin
          m_mode  = "verify";
          m_match = 1;
        end else begin
          m_mode = "slip";
        end
      end
    end else if (prev == "slip") begin
      m_mode = "wait";
      m_wait = 0;
    end else if (prev == "wait") begin
      if (v_i) begin
        m_wait++;
        if (m_wait == SLIP_WAIT) m_mode = "hunt";
      end
    end else if (prev == "verify") begin
      if (v_i) begin
        if (hit) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_mode = "locked";
            m_loss = 0;
          end
        end else begin
          m_mode = "slip";
        end
      end
    end else if (prev == "locked") begin
      if (v_i) begin
        if (err_i) begin
          m_loss++;
          if (m_loss == LOSS_CNT) m_mode = "hunt";
        end else begin
          m_loss = 0;
        end
      end
    end
    e_bitslip = en_i && (m_mode == "slip");
    if (e_bitslip) begin
      m_slips = (m_slips + 1) % WIDTH;
      if (m_slips == 0) e_aerr = 1'b1;
    end
    e_locked = (m_mode == "locked");
    if ((prev == "locked") && (m_mode == "locked")) begin
      e_dout   = din_i;
      e_dvalid = v_i;
    end else begin
      e_dvalid = 1'b0;
    end
  endtask

  // Drive one word, clock it in, then compare every output with the model.
  task automatic applyStimulus(input logic en_i, input logic [7:0] din_i, input logic v_i, input logic err_i);
    en        = en_i;
    din       = din_i;
    din_valid = v_i;
    din_err   = err_i;
    @(posedge clk);
    model_step(en_i, din_i, v_i, err_i);
    #1;
    checkOutput("model_bitslip", bitslip, e_bitslip);
    checkOutput("model_locked", locked, e_locked);
    checkOutput("model_align_err", align_err, e_aerr);
    checkOutput("model_slip_cnt", slip_cnt, m_slips);
    checkOutput("model_dout_valid", dout_valid, e_dvalid);
    checkOutput("model_dout", dout, e_dout);
    if (bitslip) begin
      checkOutput("bitslip_back_to_back", prev_bitslip, 1'b0);
      gb_mis = (gb_mis + WIDTH - 1) % WIDTH;
    end
    prev_bitslip = bitslip;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    din_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    prev_bitslip = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // The lock/loss walk: expected values after the last repetition of each row.
    vecs[0]  = '{1'b1, 8'h35, 1'b1, 1'b0,  1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h35, 1'b1, 1'b0, 15, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h35, 1'b1, 1'b0,  1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0,  1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b1, 8'h5A, 1'b0, 1'b0,  1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h5A};
    vecs[5]  = '{1'b1, 8'h11, 1'b1, 1'b1,  3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h11};
    vecs[6]  = '{1'b1, 8'h22, 1'b1, 1'b0,  1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h22};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b1,  3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h33};
    vecs[8]  = '{1'b1, 8'h44, 1'b0, 1'b1,  2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h44};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b1,  1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h44};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b0,  1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h44};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b0,  1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h44};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0,  1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h44};

    // Reset state, observed while reset is still held.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_bitslip", bitslip, 1'b0);
    checkOutput("reset_locked", locked, 1'b0);
    checkOutput("reset_align_err", align_err, 1'b0);
    checkOutput("reset_slip_cnt", slip_cnt, 3'd0);
    checkOutput("reset_dout_valid", dout_valid, 1'b0);
    checkOutput("reset_dout", dout, 8'h00);

    // Constant vector table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        applyStimulus(vecs[i].en, vecs[i].din, vecs[i].valid, vecs[i].err);
      end
      checkOutput($sformatf("vec%0d_locked", i), locked, vecs[i].e_locked);
      checkOutput($sformatf("vec%0d_bitslip", i), bitslip, vecs[i].e_bitslip);
      checkOutput($sformatf("vec%0d_slip_cnt", i), slip_cnt, vecs[i].e_slip);
      checkOutput($sformatf("vec%0d_align_err", i), align_err, vecs[i].e_aerr);
      checkOutput($sformatf("vec%0d_dout_valid", i), dout_valid, vecs[i].e_dvalid);
      checkOutput($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
    end

    // Misframed by three bits: three slips, each followed by the settle words.
    do_reset();
    gb_mis    = 3;
    n_slips   = 0;
    last_slip = 0;
    for (int c = 0; c < 400 && !locked; c++) begin
      applyStimulus(1'b1, rotl8(TRAIN, gb_mis), 1'b1, 1'b0);
      if (bitslip) begin
        if (n_slips > 0) checkOutput("misframe_slip_gap", (c - last_slip) >= (SLIP_WAIT + 1), 1'b1);
        n_slips++;
        last_slip = c;
      end
    end
    checkOutput("misframe_locked", locked, 1'b1);
    checkOutput("misframe_slips", n_slips, 3);
    checkOutput("misframe_slip_cnt", slip_cnt, 3'd3);

    // Training word never seen: the slip count wraps and align_err sticks.
    do_reset();
    n_slips = 0;
    for (int c = 0; c < 400 && n_slips < 8; c++) begin
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      if (bitslip) n_slips++;
    end
    checkOutput("noalign_slips", n_slips, 8);
    checkOutput("noalign_align_err", align_err, 1'b1);
    checkOutput("noalign_slip_cnt", slip_cnt, 3'd0);
    n_slips = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      if (bitslip) n_slips++;
    end
    checkOutput("noalign_keeps_slipping", n_slips > 0, 1'b1);
    checkOutput("noalign_err_sticky", align_err, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("noalign_en_clears", align_err, 1'b0);
    checkOutput("noalign_en_clears_cnt", slip_cnt, 3'd0);

    // Gapped input: only valid words advance the lock count.
    do_reset();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    nvalid = 0;
    for (int c = 0; c < 200 && !locked; c++) begin
      v_bit = ((c % 2) == 0);
      applyStimulus(1'b1, TRAIN, v_bit, 1'b0);
      if (v_bit) nvalid++;
    end
    checkOutput("gapped_lock_words", nvalid, LOCK_CNT);
    checkOutput("gapped_locked", locked, 1'b1);
    for (int c = 0; c < 12; c++) begin
      d_byte = 8'($urandom);
      v_bit  = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, d_byte, v_bit, 1'b0);
      checkOutput("gapped_dout_valid", dout_valid, v_bit);
      checkOutput("gapped_dout", dout, d_byte);
    end

    // Asynchronous reset pulse while locked.
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_locked", locked, 1'b0);
    checkOutput("async_rst_bitslip", bitslip, 1'b0);
    checkOutput("async_rst_align_err", align_err, 1'b0);
    checkOutput("async_rst_slip_cnt", slip_cnt, 3'd0);
    checkOutput("async_rst_dout_valid", dout_valid, 1'b0);
    checkOutput("async_rst_dout", dout, 8'h00);
    model_reset();
    prev_bitslip = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, TRAIN, 1'b1, 1'b0);
    checkOutput("post_rst_not_locked_yet", locked, 1'b0);
    applyStimulus(1'b1, TRAIN, 1'b1, 1'b0);
    checkOutput("post_rst_locked", locked, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    gb_mis      = $urandom_range(0, 7);
    lock_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      e_bit = ($urandom_range(0, 199) != 0);
      v_bit = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) d_byte = 8'($urandom);
      else d_byte = rotl8(TRAIN, gb_mis);
      if (m_mode == "locked") r_err = ($urandom_range(0, 99) < 40);
      else r_err = 1'($urandom_range(0, 1));
      applyStimulus(e_bit, d_byte, v_bit, r_err);
      if (locked) lock_cycles++;
    end
    checkOutput("random_reached_lock", lock_cycles > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
